sd_frame_serializer: RTL and testbench



---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_beat_counter.sv | 37 +++
 rtl/sd_frame_serializer.sv | 134 +++++++++++++
 tb/tb_sd_frame_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD host serial datapath (serializer and,
// later, the deserializer).
`timescale 1ns/1ps
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sd_ser_state_t;

  localparam int   SD_CMD_FRAME_BITS = 48;
  localparam int   SD_DAT_LANES      = 4;
  localparam logic SD_IDLE_LEVEL     = 1'b1;

  // Number of lane beats needed to move one frame.
  function automatic int sd_beats(input int frame, input int lanes);
    return frame / lanes;
  endfunction

endpackage

// File: rtl/sd_beat_counter.sv
// Loadable down-counter with enable and terminal-count flag; counting stops at
// zero so tc_o stays high until the next load.
`timescale 1ns/1ps
module sd_beat_counter #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sd_frame_serializer.sv
// Parallel-to-serial frame shifter for the SD CMD line (1 lane) or DAT[3:0]
// (4 lanes), with load/busy/complete handshake and enable-driven pause.
`timescale 1ns/1ps
module sd_frame_serializer
  import sd_pkg::*;
#(
  parameter int   FRAME_BITS = SD_CMD_FRAME_BITS,
  parameter int   LANES      = 1,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = SD_IDLE_LEVEL
) (
  input  logic                  iClock_SD,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iLoad_send,
  input  logic [FRAME_BITS-1:0] iParallel,
  output logic [LANES-1:0]      oSerial,
  output logic                  oOutput_enable,
  output logic                  oBusy,
  output logic                  oComplete
);

  localparam int BEATS = sd_beats(FRAME_BITS, LANES);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [LANES-1:0] IDLE_LANES = {LANES{IDLE_LEVEL}};

  if ((LANES != 1) && (LANES != 4)) begin : g_bad_lanes
    $error("sd_frame_serializer: LANES must be 1 or 4");
  end
  if ((FRAME_BITS % LANES) != 0) begin : g_bad_split
    $error("sd_frame_serializer: FRAME_BITS must be a multiple of LANES");
  end
  if ((FRAME_BITS < 8) || (FRAME_BITS > 4096)) begin : g_bad_frame
    $error("sd_frame_serializer: FRAME_BITS must be within 8..4096");
  end

  sd_ser_state_t           state_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [LANES-1:0]        serial_q;
  logic                    oe_q;
  logic                    busy_q;
  logic                    complete_q;

  logic                    accept_d;
  logic                    dec_d;
  logic                    tc;
  logic [FRAME_BITS-1:0]   src_d;
  logic [FRAME_BITS-1:0]   rest_d;
  logic [LANES-1:0]        beat_d;

  assign accept_d = iEnable && iLoad_send && ((state_q == IDLE) || (state_q == DONE));
  assign dec_d    = iEnable && (state_q == SHIFT) && !tc;

  // Beat 0 goes straight from iParallel to the lanes on the accepting edge,
  // so the shift register only ever holds the beats still to come.
  always_comb begin
    src_d  = accept_d ? iParallel : shreg_q;
    beat_d = '0;
    rest_d = '0;
    if (MSB_FIRST) begin
      beat_d = src_d[FRAME_BITS-1 -: LANES];
      rest_d = src_d << LANES;
    end else begin
      beat_d = src_d[LANES-1:0];
      rest_d = src_d >> LANES;
    end
  end

  sd_beat_counter #(
    .W(CNT_W)
  ) u_beat_counter (
    .clk_i      (iClock_SD),
    .rst_i      (iReset),
    .load_i     (accept_d),
    .load_val_i (CNT_W'(BEATS - 1)),
    .dec_i      (dec_d),
    .tc_o       (tc)
  );

  always_ff @(posedge iClock_SD) begin
    if (iReset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      serial_q   <= IDLE_LANES;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else if (iEnable) begin
      case (state_q)
        IDLE, DONE: begin
          if (iLoad_send) begin
            state_q    <= SHIFT;
            shreg_q    <= rest_d;
            serial_q   <= beat_d;
            oe_q       <= 1'b1;
            busy_q     <= 1'b1;
            complete_q <= 1'b0;
          end else begin
            state_q    <= IDLE;
            serial_q   <= IDLE_LANES;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (tc) begin
            state_q    <= DONE;
            serial_q   <= IDLE_LANES;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b1;
          end else begin
            shreg_q  <= rest_d;
            serial_q <= beat_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          serial_q   <= IDLE_LANES;
          oe_q       <= 1'b0;
          busy_q     <= 1'b0;
          complete_q <= 1'b0;
        end
      endcase
    end
  end

  assign oSerial        = serial_q;
  assign oOutput_enable = oe_q;
  assign oBusy          = busy_q;
  assign oComplete      = complete_q;

endmodule

// File: tb/tb_sd_frame_serializer.sv
// Directed bench: a CMD-line instance (48 bits, 1 lane, MSB first) and a
// 16-bit 4-lane LSB-first instance sharing one clock and reset.
`timescale 1ns/1ps
module tb_sd_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_c, ld_c;
  logic [47:0] par_c;
  logic        ser_c, oe_c, busy_c, cmp_c;

  logic        en_d, ld_d;
  logic [15:0] par_d;
  logic [3:0]  ser_d;
  logic        oe_d, busy_d, cmp_d;

  int nvec = 0;
  int nerr = 0;

  localparam logic [47:0] CMD0 = 48'h400000000095;

  sd_frame_serializer dut_cmd (
    .iClock_SD      (clk),
    .iReset         (rst),
    .iEnable        (en_c),
    .iLoad_send     (ld_c),
    .iParallel      (par_c),
    .oSerial        (ser_c),
    .oOutput_enable (oe_c),
    .oBusy          (busy_c),
    .oComplete      (cmp_c)
  );

  sd_frame_serializer #(
    .FRAME_BITS (16),
    .LANES      (4),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) dut_dat (
    .iClock_SD      (clk),
    .iReset         (rst),
    .iEnable        (en_d),
    .iLoad_send     (ld_d),
    .iParallel      (par_d),
    .oSerial        (ser_d),
    .oOutput_enable (oe_d),
    .oBusy          (busy_d),
    .oComplete      (cmp_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {serial, oe, busy, complete}
  task automatic chk_cmd(input string tag, input logic [3:0] exp);
    chk(tag, 64'({ser_c, oe_c, busy_c, cmp_c}), 64'(exp));
  endtask

  task automatic chk_dat(input string tag, input logic [6:0] exp);
    chk(tag, 64'({ser_d, oe_d, busy_d, cmp_d}), 64'(exp));
  endtask

  task automatic send_cmd(input logic [47:0] f, input string tag, output logic [47:0] rx);
    rx    = '0;
    par_c = f;
    ld_c  = 1'b1;
    tick();
    ld_c  = 1'b0;
    par_c = '0;
    for (int k = 0; k < 48; k++) begin
      chk({tag, " beat"}, 64'(ser_c), 64'(f[47-k]));
      chk({tag, " oe/busy/cmp in frame"}, 64'({oe_c, busy_c, cmp_c}), 64'(3'b110));
      rx = {rx[46:0], ser_c};
      tick();
    end
    chk_cmd({tag, " done cycle"}, 4'b1001);
    tick();
    chk_cmd({tag, " back to idle"}, 4'b1000);
  endtask

  initial begin
    logic [47:0] rx;
    logic [47:0] rx2;
    logic [47:0] f;
    logic [3:0]  nib [4];
    int          idx;

    rst  = 1'b1;
    en_c = 1'b1; ld_c = 1'b0; par_c = '0;
    en_d = 1'b1; ld_d = 1'b0; par_d = '0;

    // reset and idle
    repeat (5) tick();
    chk_cmd("reset cmd", 4'b1000);
    chk_dat("reset dat", 7'b1111_000);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cmd("idle cmd", 4'b1000);
      chk_dat("idle dat", 7'b1111_000);
    end

    // reset wins over a simultaneous load
    rst = 1'b1; ld_c = 1'b1; par_c = CMD0;
    tick();
    rst = 1'b0; ld_c = 1'b0; par_c = '0;
    chk_cmd("reset vs load", 4'b1000);
    tick();
    chk_cmd("reset vs load next", 4'b1000);

    // CMD0 frame
    send_cmd(CMD0, "cmd0", rx);
    chk("cmd0 first 8 bits", 64'(rx[47:40]), 64'(8'b0100_0000));
    chk("cmd0 last 8 bits", 64'(rx[7:0]), 64'(8'b1001_0101));
    chk("cmd0 whole frame", 64'(rx), 64'(48'h400000000095));

    // 4-lane LSB-first
    nib[0] = 4'h3; nib[1] = 4'hC; nib[2] = 4'h5; nib[3] = 4'hA;
    par_d = 16'hA5C3;
    ld_d  = 1'b1;
    tick();
    ld_d  = 1'b0;
    par_d = '0;
    for (int k = 0; k < 4; k++) begin
      chk_dat("dat nibble", {nib[k], 3'b110});
      tick();
    end
    chk_dat("dat done cycle", 7'b1111_001);
    tick();
    chk_dat("dat idle", 7'b1111_000);

    // pause: enable low for 3 edges starting while beat 10 is out
    f     = CMD0;
    rx    = '0;
    par_c = f;
    ld_c  = 1'b1;
    tick();
    ld_c  = 1'b0;
    par_c = '0;
    for (int c = 1; c <= 51; c++) begin
      idx = (c <= 11) ? c - 1 : ((c <= 14) ? 10 : c - 4);
      chk("pause beat", 64'(ser_c), 64'(f[47-idx]));
      chk("pause oe/busy/cmp", 64'({oe_c, busy_c, cmp_c}), 64'(3'b110));
      if ((c < 12) || (c > 14)) rx = {rx[46:0], ser_c};
      en_c = ((c >= 11) && (c <= 13)) ? 1'b0 : 1'b1;
      tick();
    end
    chk_cmd("pause done at L+52", 4'b1001);
    chk("pause frame order", 64'(rx), 64'(48'h400000000095));
    en_c = 1'b0;
    tick();
    chk_cmd("frozen in done", 4'b1001);
    en_c = 1'b1;
    tick();
    chk_cmd("done released", 4'b1000);

    // ignored load mid-frame, then back-to-back load in the done cycle
    f     = CMD0;
    rx    = '0;
    par_c = f;
    ld_c  = 1'b1;
    tick();
    for (int c = 1; c <= 48; c++) begin
      chk("b2b first beat", 64'(ser_c), 64'(f[48-c]));
      chk("b2b first oe/busy/cmp", 64'({oe_c, busy_c, cmp_c}), 64'(3'b110));
      rx    = {rx[46:0], ser_c};
      ld_c  = (c == 6);
      par_c = (c == 6) ? 48'h123456789ABC : 48'h0;
      tick();
    end
    chk_cmd("b2b idle cycle L+49", 4'b1001);
    chk("b2b first frame", 64'(rx), 64'(48'h400000000095));
    ld_c  = 1'b1;
    par_c = 48'h7FFFFFFFFFFF;
    tick();
    ld_c  = 1'b0;
    par_c = '0;
    chk_cmd("b2b second beat0 at L+50", 4'b0110);
    rx2 = {47'd0, ser_c};
    tick();
    for (int c = 51; c <= 97; c++) begin
      chk_cmd("b2b second beat", 4'b1110);
      rx2 = {rx2[46:0], ser_c};
      tick();
    end
    chk_cmd("b2b second done", 4'b1001);
    chk("b2b second frame", 64'(rx2), 64'(48'h7FFFFFFFFFFF));
    tick();
    chk_cmd("b2b idle", 4'b1000);

    // reset mid-frame at beat 20
    f     = CMD0;
    par_c = f;
    ld_c  = 1'b1;
    tick();
    ld_c  = 1'b0;
    par_c = '0;
    for (int c = 1; c <= 21; c++) begin
      chk("pre-reset beat", 64'(ser_c), 64'(f[48-c]));
      if (c == 21) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk_cmd("after mid-frame reset", 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cmd("no complete after abort", 4'b1000);
    end
    send_cmd(48'hC0FFEE123457, "post-reset", rx);
    chk("post-reset frame", 64'(rx), 64'(48'hC0FFEE123457));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
